// File: rtl/bcd_countdown_timer_pkg.sv
// rtl/bcd_countdown_timer_pkg.sv - shared state type, BCD limits and digit check for the countdown timer
package bcd_countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_ONES_MAX = 4'd9;
  localparam logic [3:0] BCD_TENS_MAX = 4'd5;

  // True when a packed {tens, ones} byte is legal for a field whose tens digit tops out at tens_max.
  function automatic logic bcd_valid(input logic [7:0] value, input logic [3:0] tens_max);
    return (value[3:0] <= BCD_ONES_MAX) && (value[7:4] <= tens_max);
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_digit.sv
// rtl/bcd_countdown_timer_digit.sv - one BCD digit down-counter with borrow chaining
module bcd_digit_down
  import bcd_countdown_timer_pkg::*;
#(
  parameter logic [3:0] WRAP = BCD_ONES_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic [3:0] digit,
  output logic       borrow_out
);

  always_ff @(posedge clk) begin
    if (reset) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= load_val;
    end else if (en) begin
      digit <= (digit == 4'd0) ? WRAP : digit - 4'd1;
    end
  end

  assign borrow_out = en && (digit == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - BCD hh:mm:ss down-counter with load validation, pause and expiry
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int AUTO_RELOAD = 0,
  parameter int HH_TENS_MAX = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       running,
  output logic       done,
  output logic       expired,
  output logic       load_err
);

  localparam logic [3:0] HH_TENS_LIM = 4'(HH_TENS_MAX);
  localparam bit         RELOAD_EN   = (AUTO_RELOAD != 0);

  state_t      state_q;
  state_t      state_n;
  logic [23:0] reload_q;
  logic [23:0] count;
  logic [23:0] dig_val;
  logic [3:0]  digit [6];
  logic [5:0]  en;
  logic [5:0]  borrow;
  logic        chain_unused;

  logic load_ok;
  logic is_zero;
  logic at_one;
  logic dec;
  logic expire;
  logic reload_now;
  logic dig_load;

  assign load_ok = load
                 && bcd_valid(load_hh, HH_TENS_LIM)
                 && bcd_valid(load_mm, BCD_TENS_MAX)
                 && bcd_valid(load_ss, BCD_TENS_MAX);

  assign count   = {digit[5], digit[4], digit[3], digit[2], digit[1], digit[0]};
  assign is_zero = (count == 24'h000000);
  assign at_one  = (count == 24'h000001);

  // A valid load or a pause in RUN both swallow the tick; an invalid load does not.
  assign dec        = (state_q == ST_RUN) && tick && !load_ok && !pause;
  assign expire     = dec && at_one;
  assign reload_now = expire && RELOAD_EN;
  assign dig_load   = load_ok || reload_now;
  assign dig_val    = load_ok ? {load_hh, load_mm, load_ss} : reload_q;

  assign en[0]        = dec;
  assign en[5:1]      = borrow[4:0];
  assign chain_unused = borrow[5];

  // Digit 0 is ss ones, digit 5 is hh tens; odd minute/second positions wrap to 5.
  for (genvar i = 0; i < 6; i++) begin : g_digit
    localparam logic [3:0] WRAP_V = (i == 1 || i == 3) ? BCD_TENS_MAX
                                  : (i == 5)           ? HH_TENS_LIM
                                  :                      BCD_ONES_MAX;
    bcd_digit_down #(.WRAP(WRAP_V)) u_digit (
      .clk       (clk),
      .reset     (reset),
      .load      (dig_load),
      .load_val  (dig_val[4*i +: 4]),
      .en        (en[i]),
      .digit     (digit[i]),
      .borrow_out(borrow[i])
    );
  end

  assign hh = count[23:16];
  assign mm = count[15:8];
  assign ss = count[7:0];

  always_comb begin
    state_n = state_q;
    if (load_ok) begin
      state_n = ST_IDLE;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pause) begin
            state_n = ST_PAUSE;
          end else if (expire && !RELOAD_EN) begin
            state_n = ST_DONE;
          end
        end
        ST_IDLE, ST_PAUSE: begin
          if (start && !is_zero) begin
            state_n = ST_RUN;
          end
        end
        ST_DONE: state_n = ST_DONE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      reload_q <= 24'h000000;
      running  <= 1'b0;
      done     <= 1'b0;
      expired  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state_q  <= state_n;
      running  <= (state_n == ST_RUN);
      done     <= (state_n == ST_DONE);
      expired  <= expire;
      load_err <= load && !load_ok;
      if (load_ok) begin
        reload_q <= {load_hh, load_mm, load_ss};
      end
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - directed and randomized checks of both reload variants against a seconds-based model
module tb_bcd_countdown_timer;

  logic       clk = 1'b0;
  logic       reset, tick, load, start, pause;
  logic [7:0] load_hh, load_mm, load_ss;
  logic [7:0] hh0, mm0, ss0, hh1, mm1, ss1;
  logic       running0, done0, expired0, load_err0;
  logic       running1, done1, expired1, load_err1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: count and reload kept as plain seconds.
  int m_cnt [2];
  int m_rel [2];
  bit m_run [2];
  bit m_done[2];
  bit m_exp [2];
  bit m_err [2];

  always #5 clk = ~clk;

  bcd_countdown_timer #(.AUTO_RELOAD(0), .HH_TENS_MAX(9)) u_dut0 (
    .clk(clk), .reset(reset), .tick(tick), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .start(start), .pause(pause),
    .hh(hh0), .mm(mm0), .ss(ss0),
    .running(running0), .done(done0), .expired(expired0), .load_err(load_err0)
  );

  bcd_countdown_timer #(.AUTO_RELOAD(1), .HH_TENS_MAX(9)) u_dut1 (
    .clk(clk), .reset(reset), .tick(tick), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .start(start), .pause(pause),
    .hh(hh1), .mm(mm1), .ss(ss1),
    .running(running1), .done(done1), .expired(expired1), .load_err(load_err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int bcd2int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int x);
    return 8'(((x / 10) << 4) | (x % 10));
  endfunction

  function automatic bit field_ok(input logic [7:0] b, input int tens_max);
    return (int'(b[3:0]) <= 9) && (int'(b[7:4]) <= tens_max);
  endfunction

  task automatic model_step(input int k);
    bit ok;
    ok = field_ok(load_hh, 9) && field_ok(load_mm, 5) && field_ok(load_ss, 5);
    m_exp[k] = 0;
    m_err[k] = 0;
    if (reset) begin
      m_cnt[k] = 0; m_rel[k] = 0; m_run[k] = 0; m_done[k] = 0;
    end else if (load && ok) begin
      m_cnt[k] = bcd2int(load_hh) * 3600 + bcd2int(load_mm) * 60 + bcd2int(load_ss);
      m_rel[k] = m_cnt[k];
      m_run[k] = 0;
      m_done[k] = 0;
    end else begin
      if (load) m_err[k] = 1;
      if (m_run[k]) begin
        if (pause) m_run[k] = 0;
        else if (tick) begin
          m_cnt[k] = m_cnt[k] - 1;
          if (m_cnt[k] == 0) begin
            m_exp[k] = 1;
            if (k == 1) m_cnt[k] = m_rel[k];
            else begin
              m_run[k] = 0;
              m_done[k] = 1;
            end
          end
        end
      end else if (!m_done[k] && start && m_cnt[k] != 0) begin
        m_run[k] = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("hh0", hh0, int2bcd(m_cnt[0] / 3600));
    check("mm0", mm0, int2bcd((m_cnt[0] / 60) % 60));
    check("ss0", ss0, int2bcd(m_cnt[0] % 60));
    check("running0", running0, m_run[0]);
    check("done0", done0, m_done[0]);
    check("expired0", expired0, m_exp[0]);
    check("load_err0", load_err0, m_err[0]);
    check("hh1", hh1, int2bcd(m_cnt[1] / 3600));
    check("mm1", mm1, int2bcd((m_cnt[1] / 60) % 60));
    check("ss1", ss1, int2bcd(m_cnt[1] % 60));
    check("running1", running1, m_run[1]);
    check("done1", done1, m_done[1]);
    check("expired1", expired1, m_exp[1]);
    check("load_err1", load_err1, m_err[1]);
  endtask

  task automatic clear_inputs();
    reset = 0; tick = 0; load = 0; start = 0; pause = 0;
    load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h00;
  endtask

  // Inputs are set just after a rising edge, consumed at the next one, and outputs sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
    clear_inputs();
  endtask

  task automatic set_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    load = 1; load_hh = h; load_mm = m; load_ss = s;
  endtask

  initial begin
    logic [7:0] exp_ss [6];
    exp_ss = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h59};
    clear_inputs();

    reset = 1; step();
    check("rst_hh", hh0, 8'h00);
    check("rst_running", running0, 1'b0);

    // 00:01:05 counting across a minute borrow
    set_load(8'h00, 8'h01, 8'h05); step();
    start = 1; step();
    for (int i = 0; i < 6; i++) begin
      tick = 1; step();
      check("tp1_ss", ss0, exp_ss[i]);
    end
    check("tp1_mm", mm0, 8'h00);
    check("tp1_running", running0, 1'b1);

    // expiry at zero, then DONE holds
    set_load(8'h00, 8'h00, 8'h02); step();
    start = 1; tick = 1; step();
    check("tp2_no_dec_on_start", ss0, 8'h02);
    tick = 1; step();
    check("tp2_ss1", ss0, 8'h01);
    tick = 1; step();
    check("tp2_expired", expired0, 1'b1);
    check("tp2_done", done0, 1'b1);
    check("tp2_running", running0, 1'b0);
    tick = 1; step();
    check("tp2_expired_pulse", expired0, 1'b0);
    start = 1; step();
    tick = 1; step();
    check("tp2_hold_zero", ss0, 8'h00);
    check("tp2_done_hold", done0, 1'b1);

    // full borrow chain
    set_load(8'h10, 8'h00, 8'h00); step();
    start = 1; step();
    tick = 1; step();
    check("tp3_hh", hh0, 8'h09);
    check("tp3_mm", mm0, 8'h59);
    check("tp3_ss", ss0, 8'h59);

    // pause freezes the count
    set_load(8'h00, 8'h00, 8'h30); step();
    start = 1; step();
    pause = 1; step();
    for (int i = 0; i < 3; i++) begin
      tick = 1; step();
    end
    check("tp4_frozen", ss0, 8'h30);
    start = 1; step();
    tick = 1; step();
    check("tp4_ss29", ss0, 8'h29);
    start = 1; pause = 1; step();
    check("tp4_pause_wins", running0, 1'b0);

    // rejected loads, then a valid load mid-run with a tick
    set_load(8'h00, 8'h60, 8'h00); step();
    check("tp5_err_mm", load_err0, 1'b1);
    check("tp5_keep_ss", ss0, 8'h29);
    step();
    check("tp5_err_pulse", load_err0, 1'b0);
    set_load(8'h00, 8'h00, 8'h0A); step();
    check("tp5_err_ss", load_err0, 1'b1);
    start = 1; step();
    check("tp5_resume", running0, 1'b1);
    set_load(8'h00, 8'h00, 8'h45); tick = 1; step();
    check("tp5_load_run", ss0, 8'h45);
    check("tp5_idle", running0, 1'b0);

    // auto-reload variant
    set_load(8'h00, 8'h00, 8'h03); step();
    start = 1; step();
    for (int i = 0; i < 3; i++) begin
      tick = 1; step();
    end
    check("tp6_expired", expired1, 1'b1);
    check("tp6_reload", ss1, 8'h03);
    check("tp6_running", running1, 1'b1);
    tick = 1; step();
    check("tp6_ss2", ss1, 8'h02);
    reset = 1; step();
    check("tp6_rst_ss", ss1, 8'h00);
    check("tp6_rst_running", running1, 1'b0);
    check("tp6_rst_expired", expired1, 1'b0);

    // randomized traffic, durations kept short so expiry happens often
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) < 4) begin
        set_load(($urandom_range(0, 7) == 0) ? int2bcd($urandom_range(0, 99)) : 8'h00,
                 int2bcd($urandom_range(0, 1)),
                 int2bcd($urandom_range(0, 59)));
        case ($urandom_range(0, 9))
          0: load_ss = {4'($urandom_range(6, 15)), load_ss[3:0]};
          1: load_mm = {load_mm[7:4], 4'($urandom_range(10, 15))};
          2: load_hh = {4'($urandom_range(10, 15)), load_hh[3:0]};
          default: ;
        endcase
      end
      tick  = ($urandom_range(0, 2) == 0);
      start = ($urandom_range(0, 7) == 0);
      pause = ($urandom_range(0, 19) == 0);
      if (start) tick = 0;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- BCD hours:minutes:seconds down-counter; the count-down counterpart of the team's 12-hour BCD time-of-day clock.
- Software or panel logic loads a duration, starts it, and may pause it. The block decrements once per tick enable and flags expiry at 00:00:00.
- Outputs use the same packed-BCD byte format as the time-of-day clock ({tens, ones} per field), so they feed the same display path.

Parameters:
- AUTO_RELOAD, 0: 1 = on expiry, reload the last accepted duration and keep running.
- HH_TENS_MAX, 9: maximum legal hours tens digit at load (hours range 00..99 by default).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- tick  input  1  one-cycle count enable (1 Hz strobe); 1-cycle pulse on clk
- load  input  1  load request, sampled every cycle
- load_hh  input  8  BCD hours {tens, ones}
- load_mm  input  8  BCD minutes
- load_ss  input  8  BCD seconds
- start  input  1  run request
- pause  input  1  pause request
- hh  output  8  current BCD hours
- mm  output  8  current BCD minutes
- ss  output  8  current BCD seconds
- running  output  1  high while state is RUN
- done  output  1  high while state is DONE
- expired  output  1  one-cycle pulse on reaching zero
- load_err  output  1  one-cycle pulse on a rejected load

Behaviour:
- Interface: reset is synchronous and active-high; clock is clk. All outputs are registered.
- Reset values: hh=mm=ss=8'h00; reload store = 0; state IDLE; running=0, done=0, expired=0, load_err=0.
- States: IDLE, RUN, PAUSE, DONE.
- Per-cycle priority: reset > load > pause > start > tick decrement.
- Load, accepted in any state:
  - Validation rules: every ones nibble <= 9; mm and ss tens nibble <= 5; hh tens nibble <= HH_TENS_MAX.
  - Valid load: hh/mm/ss and the reload store take the inputs next cycle; state -> IDLE, including from RUN. Any same-cycle tick is discarded.
  - Invalid load: load_err pulses for 1 cycle; count, reload store and state are unchanged; the cycle's pause/start/tick are then evaluated normally.
- Start:
  - IDLE or PAUSE with nonzero count -> RUN.
  - A zero count leaves the state unchanged.
  - Start is ignored in RUN and in DONE.
- Pause:
  - RUN -> PAUSE.
  - If start and pause arrive together in RUN, pause wins.
  - In IDLE, PAUSE and DONE, pause is ignored; a simultaneous start is still evaluated.
- Decrement:
  - Occurs only when state is RUN and tick is high, one BCD step per tick.
  - ss ones 0 -> 9 with borrow; ss tens 0 -> 5 with borrow.
  - mm ones 0 -> 9 with borrow; mm tens 0 -> 5 with borrow.
  - hh ones 0 -> 9 with borrow; hh tens decrements.
  - A tick outside RUN is ignored.
  - A tick on the same cycle as the start that enters RUN does not decrement; the first decrement uses the next tick.
- Expiry: a decrement from 00:00:01 produces 00:00:00.
  - expired pulses in the same cycle the zero value appears on the outputs.
  - AUTO_RELOAD=0: state -> DONE; done=1; count holds at zero.
  - AUTO_RELOAD=1: on that same edge, hh/mm/ss take the reload store instead of zero; state stays RUN; expired still pulses.
  - A reload store of zero is impossible while running, because start requires a nonzero count.
- Leaving DONE: only by a valid load (-> IDLE) or reset.
- Reset mid-RUN: immediate return to the reset values; no expired pulse.
- Arithmetic: pure BCD. Hex digit values A..F never appear on the outputs because every load is validated.

Decomposition:
- Shared package: state enum (IDLE, RUN, PAUSE, DONE), BCD digit limit constants (9, 5), and a bcd_valid-style digit-check function.
- One sub-module: bcd_digit_down, a 4-bit down-counter with:
  - enable/borrow-in and a load value;
  - wrap value parameter;
  - borrow_out = en && digit==0.
- Instantiate bcd_digit_down six times, chained ss ones -> hh tens.
- Zero detect and the state machine stay in the top module.

Test Plan:
- Load 00:01:05, start, 6 ticks -> ss sequence 04,03,02,01,00,59 with mm 01 -> 00 on the sixth tick; running stays 1.
- Load 00:00:02, start, 2 ticks -> 00:00:01, then 00:00:00 with expired one 1-cycle pulse, done=1, running=0. Further ticks and start leave the count at 0.
- Load 10:00:00, start, 1 tick -> 09:59:59 (full borrow chain across all six digits).
- Run 00:00:30, pause, 3 ticks -> count frozen at 30. Start, 1 tick -> 29. Start+pause in same cycle while RUN -> PAUSE.
- Load mm=8'h60 (tens 6), and separately ss=8'h0A -> load_err 1-cycle pulse each, count and state unchanged. Load during RUN with tick high -> new value, IDLE, no decrement.
- AUTO_RELOAD=1: load 00:00:03, start, 3 ticks -> expired pulse and count 00:00:03 same cycle, running stays 1. Reset asserted mid-run -> 00:00:00, IDLE, no expired.
